// File: rtl/vga_pkg.sv
// Shared types and constants for the VGA window arbiter: screen geometry,
// window rectangle record and commit FSM states.
package vga_pkg;

    localparam int H_DISPLAY = 640;
    localparam int V_DISPLAY = 480;
    localparam int COORD_W   = 10;

    typedef struct packed {
        logic               en;
        logic [COORD_W-1:0] x0;
        logic [COORD_W-1:0] y0;
        logic [COORD_W-1:0] x1;
        logic [COORD_W-1:0] y1;
    } win_rect_t;

    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_COMMIT = 1'b1
    } commit_state_e;

    function automatic win_rect_t make_rect(
        input logic               en,
        input logic [COORD_W-1:0] x0,
        input logic [COORD_W-1:0] y0,
        input logic [COORD_W-1:0] x1,
        input logic [COORD_W-1:0] y1
    );
        win_rect_t r;
        r.en = en;
        r.x0 = x0;
        r.y0 = y0;
        r.x1 = x1;
        r.y1 = y1;
        return r;
    endfunction

endpackage

// File: rtl/vga_win_hit.sv
// Combinational hit test of one pixel against one inclusive window rectangle.
// An inverted rectangle (x0 > x1 or y0 > y1) can never satisfy both bounds.
module vga_win_hit
    import vga_pkg::*;
(
    input  win_rect_t          rect,
    input  logic [COORD_W-1:0] x,
    input  logic [COORD_W-1:0] y,
    output logic               hit
);

    // Unsigned inclusive bounds check on both axes
    always_comb begin
        hit = rect.en
            & (x >= rect.x0) & (x <= rect.x1)
            & (y >= rect.y0) & (y <= rect.y1);
    end

endmodule

// File: rtl/vga_window_arbiter.sv
// Arbitrates the VGA pixel stream between up to four windows and a background,
// with double-buffered window rectangles committed on the vsync falling edge.
module vga_window_arbiter
    import vga_pkg::*;
#(
    parameter int NUM_WIN = 4,
    parameter int COLOR_W = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       p_tick,
    input  logic                       video_on,
    input  logic [COORD_W-1:0]         x,
    input  logic [COORD_W-1:0]         y,
    input  logic                       vsync,
    input  logic                       cfg_valid,
    output logic                       cfg_ready,
    input  logic [1:0]                 cfg_win,
    input  logic                       cfg_en,
    input  logic [COORD_W-1:0]         cfg_x0,
    input  logic [COORD_W-1:0]         cfg_y0,
    input  logic [COORD_W-1:0]         cfg_x1,
    input  logic [COORD_W-1:0]         cfg_y1,
    input  logic [NUM_WIN*COLOR_W-1:0] win_color,
    input  logic [COLOR_W-1:0]         bg_color,
    output logic [COLOR_W-1:0]         pix_color,
    output logic [NUM_WIN-1:0]         pix_grant,
    output logic                       frame_start,
    output logic                       cfg_pending
);

    commit_state_e state_q;
    logic          vs_q;
    logic          cfg_ready_q;
    logic          frame_start_q;

    win_rect_t pend_q [NUM_WIN];
    win_rect_t pend_d [NUM_WIN];
    win_rect_t act_q  [NUM_WIN];
    win_rect_t act_d  [NUM_WIN];
    logic      cfg_pending_q, cfg_pending_d;

    logic [NUM_WIN-1:0]         hit_s;
    logic [NUM_WIN-1:0]         hit1_q, hit1_d;
    logic [NUM_WIN*COLOR_W-1:0] col1_q, col1_d;
    logic [COLOR_W-1:0]         bg1_q, bg1_d;
    logic                       bgv1_q, bgv1_d;
    logic [COLOR_W-1:0]         pix_color_q, pix_color_d;
    logic [NUM_WIN-1:0]         pix_grant_q, pix_grant_d;

    logic      accept_s;
    win_rect_t new_rect_s;

    assign accept_s   = cfg_valid & cfg_ready_q;
    assign new_rect_s = make_rect(cfg_en, cfg_x0, cfg_y0, cfg_x1, cfg_y1);

    for (genvar g = 0; g < NUM_WIN; g++) begin : g_hit
        vga_win_hit u_hit (
            .rect (act_q[g]),
            .x    (x),
            .y    (y),
            .hit  (hit_s[g])
        );
    end

    // Commit FSM: detects the vsync falling edge on p_tick and spends one clk in COMMIT
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_RUN;
            vs_q          <= 1'b1;
            cfg_ready_q   <= 1'b1;
            frame_start_q <= 1'b0;
        end else begin
            if (p_tick) begin
                vs_q <= vsync;
            end else begin
                vs_q <= vs_q;
            end
            case (state_q)
                ST_RUN: begin
                    if (p_tick && vs_q && !vsync) begin
                        state_q       <= ST_COMMIT;
                        cfg_ready_q   <= 1'b0;
                        frame_start_q <= 1'b1;
                    end else begin
                        state_q       <= ST_RUN;
                        cfg_ready_q   <= 1'b1;
                        frame_start_q <= 1'b0;
                    end
                end
                ST_COMMIT: begin
                    state_q       <= ST_RUN;
                    cfg_ready_q   <= 1'b1;
                    frame_start_q <= 1'b0;
                end
                default: begin
                    state_q       <= ST_RUN;
                    cfg_ready_q   <= 1'b1;
                    frame_start_q <= 1'b0;
                end
            endcase
        end
    end

    // Bank update: writes land in pending, COMMIT copies pending into active
    always_comb begin
        pend_d        = pend_q;
        act_d         = act_q;
        cfg_pending_d = cfg_pending_q;
        if (state_q == ST_COMMIT) begin
            if (cfg_pending_q) begin
                act_d = pend_q;
            end else begin
                act_d = act_q;
            end
            cfg_pending_d = 1'b0;
        end else begin
            // Indices at or above NUM_WIN match no slot and are dropped
            for (int i = 0; i < NUM_WIN; i++) begin
                if (accept_s && (cfg_win == 2'(i))) begin
                    pend_d[i]     = new_rect_s;
                    cfg_pending_d = 1'b1;
                end else begin
                    pend_d[i] = pend_q[i];
                end
            end
        end
    end

    // Register banks
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_WIN; i++) begin
                pend_q[i] <= '0;
                act_q[i]  <= '0;
            end
            cfg_pending_q <= 1'b0;
        end else begin
            pend_q        <= pend_d;
            act_q         <= act_d;
            cfg_pending_q <= cfg_pending_d;
        end
    end

    // Stage 1 capture and stage 2 fixed-priority selection, both gated by p_tick
    always_comb begin
        hit1_d      = hit1_q;
        col1_d      = col1_q;
        bg1_d       = bg1_q;
        bgv1_d      = bgv1_q;
        pix_color_d = pix_color_q;
        pix_grant_d = pix_grant_q;
        if (p_tick) begin
            hit1_d      = hit_s & {NUM_WIN{video_on}};
            col1_d      = win_color;
            bg1_d       = bg_color;
            bgv1_d      = video_on;
            pix_color_d = bgv1_q ? bg1_q : {COLOR_W{1'b0}};
            pix_grant_d = '0;
            // Walk downward so the lowest hitting index is the last to win
            for (int i = NUM_WIN - 1; i >= 0; i--) begin
                if (hit1_q[i]) begin
                    pix_color_d    = col1_q[i*COLOR_W +: COLOR_W];
                    pix_grant_d    = '0;
                    pix_grant_d[i] = 1'b1;
                end else begin
                    pix_grant_d = pix_grant_d;
                end
            end
        end else begin
            pix_grant_d = pix_grant_q;
        end
    end

    // Pixel pipeline registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit1_q      <= '0;
            col1_q      <= '0;
            bg1_q       <= '0;
            bgv1_q      <= 1'b0;
            pix_color_q <= '0;
            pix_grant_q <= '0;
        end else begin
            hit1_q      <= hit1_d;
            col1_q      <= col1_d;
            bg1_q       <= bg1_d;
            bgv1_q      <= bgv1_d;
            pix_color_q <= pix_color_d;
            pix_grant_q <= pix_grant_d;
        end
    end

    assign cfg_ready   = cfg_ready_q;
    assign frame_start = frame_start_q;
    assign cfg_pending = cfg_pending_q;
    assign pix_color   = pix_color_q;
    assign pix_grant   = pix_grant_q;

endmodule

// File: doc/vga_window_arbiter.md
# vga_window_arbiter

Shares the VGA pixel stream produced by the `vgasync` timing generator between up to four rectangular display windows, such as the POS item list, total display and keypad echo, plus a background colour. Per-window rectangles are written through a valid/ready configuration port into a pending bank. The pending bank is committed atomically at the start of vertical sync, so the picture never tears mid-frame. For each pixel tick, the block selects the highest-priority window covering (x, y) and emits a registered colour and grant, two ticks later, to the DAC/colour pins.

## Interface
- NUM_WIN, 4: number of windows, 1–4; index 0 has highest priority.
- COLOR_W, 8: colour width per pixel (RGB332 by default).
- clk  in  1  system clock, 50 MHz.
- rst_n  in  1  **asynchronous, active-low reset**.
- p_tick  in  1  pixel enable from `vgasync`; all pixel-path registers advance only when it is high.
- video_on  in  1  display-area flag from `vgasync`.
- x, y  in  10 each  current pixel position from `vgasync`.
- vsync  in  1  active-low vertical sync from `vgasync`.
- cfg_valid  in  1  configuration write request.
- cfg_ready  out  1  configuration write can be accepted.
- cfg_win  in  2  target window index; writes with index ≥ NUM_WIN are accepted and discarded.
- cfg_en  in  1  window enable.
- cfg_x0, cfg_y0, cfg_x1, cfg_y1  in  10 each  inclusive rectangle corners.
- win_color  in  NUM_WIN*COLOR_W  per-window pixel colour; slice i belongs to window i, sampled on p_tick.
- bg_color  in  COLOR_W  colour used where no window hits.
- pix_color  out  COLOR_W  registered output colour.
- pix_grant  out  NUM_WIN  one-hot winning window; all zeros means background or blanking.
- frame_start  out  1  single-clk pulse on the commit cycle.
- cfg_pending  out  1  pending bank holds uncommitted writes.

## Operation
- **Register banks:** two banks, pending and active. Each holds, per window, en, x0, y0, x1 and y1. Reset value for both banks: en = 0, all coordinates 0.
- **Config handshake:** a write is accepted when cfg_valid and cfg_ready are both high. It updates pending[cfg_win] and sets cfg_pending. cfg_valid may stay high; each accepted cycle is one write. A later write to the same window overwrites the earlier one.
- **Commit FSM:** two states, RUN and COMMIT; reset state is RUN.
  - vsync is sampled on p_tick into vs_q.
  - RUN → COMMIT when p_tick is high and vs_q = 1 and vsync = 0 (the falling edge).
  - In COMMIT, cfg_ready = 0. If cfg_pending is set, the active bank takes a copy of the pending bank; otherwise the active bank is unchanged. cfg_pending is cleared, frame_start = 1, and the FSM returns to RUN on the next clk.
  - In RUN, cfg_ready = 1.
- **Hit test:** window i hits when en, x0 ≤ x ≤ x1 and y0 ≤ y ≤ y1, using unsigned 10-bit compares. If x0 > x1 or y0 > y1, the window never hits. Zero-area windows (x0 = x1, y0 = y1) hit exactly one pixel.
- **Pixel pipeline:**
  - Stage 1 registers the hit vector, win_color and bg_color, with video_on ANDed into every hit and into the background-valid flag.
  - Stage 2 applies a fixed-priority mux, where the lowest hit index wins, and registers pix_color and pix_grant.
  - When video_on was low, the output is pix_color = 0 and pix_grant = 0.

## Timing
- **Reset values:** pix_color = 0, pix_grant = 0, frame_start = 0, cfg_pending = 0, cfg_ready = 1, vs_q = 1, and all pipeline registers 0.
- **Pixel latency:** exactly 2 p_ticks from (x, y, video_on) to pix_color/pix_grant. Outputs hold their value between p_ticks.
- **Commit timing:** a commit takes effect for hit tests starting on the first p_tick after the COMMIT cycle. It never occurs while video_on is high, because vsync lies in blanking.
- **Config latency:** a write accepted in frame N is visible from frame N+1 at the earliest. A write accepted in the same clk that the FSM enters COMMIT cannot occur, because cfg_ready is low in COMMIT.
- **Reset mid-operation:** reset mid-frame asynchronously clears both banks and all outputs. The first commit after release needs a fresh vsync falling edge.
- **Held vsync:** vsync held low does not re-trigger a commit; a new high-to-low edge is required.

## Structure
- **Shared package `vga_pkg`:** holds H_DISPLAY = 640 and V_DISPLAY = 480, COORD_W = 10, and a packed `win_rect_t` struct {en, x0, y0, x1, y1}.
- **Sub-module `vga_win_hit`:** one instance per window; it takes a rect and (x, y) and returns the hit bit. It is purely combinational.
- **Top level:** banks, FSM and pipeline live in the top level.

## Test plan
- **Single window:** write window 0 = {en, 100, 50, 199, 149}, wait one vsync edge, then scan → pixel (100, 50) has grant 0001 and win_color[0]; (200, 50) has background; (99, 149) has background. All results appear 2 p_ticks after the input.
- **Priority overlap:** window 1 = {0, 0, 639, 479} and window 0 = {10, 10, 20, 20} → (15, 15) has grant 0001 and (30, 30) has grant 0010.
- **Atomic commit:** write window 2 mid-frame → no change until frame_start; cfg_pending = 1 until the commit; cfg_ready = 0 for exactly one clk at the commit.
- **Boundary cases:**
  - x0 = x1 = 639, y0 = y1 = 479 → only the last visible pixel hits.
  - x0 = 300, x1 = 200 → never hits.
  - cfg_win = 3 with NUM_WIN = 2 → write discarded.
- **Blanking:** window covers all coordinates and x = 700 (video_on = 0) → pix_color = 0 and pix_grant = 0.
- **Async reset:** assert rst_n low mid-line after configuring → outputs go to 0 immediately; after release, no window hits until a new write plus a vsync edge.
